// File: rtl/pconv_feeder_c6_pkg.sv
// Shared definitions for the pointwise-conv input feeder: FSM states, lane count
// and the address-width helper.
package pconv_feeder_c6_pkg;
  localparam int LANES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Keeps single-entry memories at a 1-bit address instead of a zero-width one.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pconv_feeder_c6_if.sv
// Bundle of control, memory-read and conv-unit signals around the feeder.
// master = feeder side, slave = memories / conv unit / controller side.
interface pconv_feeder_c6_if
  import pconv_feeder_c6_pkg::*;
#(
  parameter int N      = 16,
  parameter int PIXELS = 144,
  parameter int OUT_CH = 12
);
  localparam int PAW = addr_w(PIXELS);
  localparam int OAW = addr_w(OUT_CH);

  logic                 start;
  logic                 stall;
  logic                 busy;
  logic                 done;
  logic                 fm_rd_en;
  logic [PAW-1:0]       fm_addr;
  logic [LANES*N-1:0]   fm_rdata;
  logic                 w_rd_en;
  logic [OAW-1:0]       w_addr;
  logic [LANES*N-1:0]   w_rdata;
  logic [31:0]          b_rdata;
  logic [4:0]           s_rdata;
  logic                 ce;
  logic                 input_vld;
  logic [LANES*N-1:0]   input_din;
  logic [LANES*N-1:0]   weight_din;
  logic [31:0]          bias_din;
  logic [4:0]           shift_din;

  modport master (
    input  start, stall, fm_rdata, w_rdata, b_rdata, s_rdata,
    output busy, done, fm_rd_en, fm_addr, w_rd_en, w_addr, ce,
           input_vld, input_din, weight_din, bias_din, shift_din
  );

  modport slave (
    output start, stall, fm_rdata, w_rdata, b_rdata, s_rdata,
    input  busy, done, fm_rd_en, fm_addr, w_rd_en, w_addr, ce,
           input_vld, input_din, weight_din, bias_din, shift_din
  );
endinterface

// File: rtl/pconv_feeder_c6_vld_delay_line.sv
// Fixed-depth shift register carrying {valid, bias, shift} so bias/shift line up
// with the conv unit's output valid.
module vld_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_i,
  input  logic [31:0] bias_i,
  input  logic [4:0]  shift_i,
  output logic        vld_o,
  output logic [31:0] bias_o,
  output logic [4:0]  shift_o,
  output logic        pend_o
);
  logic [DEPTH-1:0] vld_q;
  logic [31:0]      bias_q  [DEPTH];
  logic [4:0]       shift_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bias_q[i]  <= '0;
        shift_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= vld_i;
      bias_q[0]  <= bias_i;
      shift_q[0] <= shift_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i]   <= vld_q[i-1];
        bias_q[i]  <= bias_q[i-1];
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  // Anything still travelling behind the output stage.
  always_comb begin
    pend_o = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      pend_o = pend_o | vld_q[i];
    end
  end

  assign vld_o   = vld_q[DEPTH-1];
  assign bias_o  = bias_q[DEPTH-1];
  assign shift_o = shift_q[DEPTH-1];
endmodule

// File: rtl/pconv_feeder_c6.sv
// Input-side sequencer for the 6-lane pointwise conv unit: walks (pixel, out-channel)
// pairs pixel-major, reads feature/weight memories and presents registered lanes.
module pconv_feeder_c6
  import pconv_feeder_c6_pkg::*;
#(
  parameter int N        = 16,
  parameter int PIXELS   = 144,
  parameter int OUT_CH   = 12,
  parameter int BIAS_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pconv_feeder_c6_if.master bus
);
  localparam int PAW = addr_w(PIXELS);
  localparam int OAW = addr_w(OUT_CH);

  state_e             state_q, state_d;
  logic [PAW-1:0]     p_q, p_d, fm_addr_q, fm_addr_d;
  logic [OAW-1:0]     oc_q, oc_d, w_addr_q, w_addr_d;
  logic               rd_en_q, rd_en_d, rdv_q;
  logic               busy_q, busy_d, done_q, done_d;
  logic               vld_q;
  logic [LANES*N-1:0] in_q, wt_q;
  logic [31:0]        bias_q;
  logic [4:0]         shift_q;
  logic               dl_vld, dl_pend;
  logic [31:0]        dl_bias;
  logic [4:0]         dl_shift;
  logic               issue, last_p, last_oc, drained;

  assign issue   = (state_q == RUN) && !bus.stall;
  assign last_p  = (p_q == PAW'(PIXELS - 1));
  assign last_oc = (oc_q == OAW'(OUT_CH - 1));
  // Final bias sits in the last delay stage with nothing behind it.
  assign drained = dl_vld && !dl_pend && !rd_en_q && !rdv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (issue && last_p && last_oc) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_d       = p_q;
    oc_d      = oc_q;
    rd_en_d   = issue;
    fm_addr_d = issue ? p_q : fm_addr_q;
    w_addr_d  = issue ? oc_q : w_addr_q;
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE);
    if (state_q == IDLE && bus.start) begin
      p_d  = '0;
      oc_d = '0;
    end else if (issue) begin
      if (last_oc) begin
        oc_d = '0;
        p_d  = last_p ? '0 : p_q + PAW'(1);
      end else begin
        oc_d = oc_q + OAW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      oc_q      <= '0;
      rd_en_q   <= 1'b0;
      fm_addr_q <= '0;
      w_addr_q  <= '0;
      rdv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      in_q      <= '0;
      wt_q      <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
    end else begin
      p_q       <= p_d;
      oc_q      <= oc_d;
      rd_en_q   <= rd_en_d;
      fm_addr_q <= fm_addr_d;
      w_addr_q  <= w_addr_d;
      rdv_q     <= rd_en_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= rdv_q;
      if (rdv_q) begin
        in_q <= bus.fm_rdata;
        wt_q <= bus.w_rdata;
      end
      if (dl_vld) begin
        bias_q  <= dl_bias;
        shift_q <= dl_shift;
      end
    end
  end

  vld_delay_line #(.DEPTH(BIAS_DLY)) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_i   (rdv_q),
    .bias_i  (bus.b_rdata),
    .shift_i (bus.s_rdata),
    .vld_o   (dl_vld),
    .bias_o  (dl_bias),
    .shift_o (dl_shift),
    .pend_o  (dl_pend)
  );

  assign bus.busy       = busy_q;
  assign bus.ce         = busy_q;
  assign bus.done       = done_q;
  assign bus.fm_rd_en   = rd_en_q;
  assign bus.w_rd_en    = rd_en_q;
  assign bus.fm_addr    = fm_addr_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.input_vld  = vld_q;
  assign bus.input_din  = in_q;
  assign bus.weight_din = wt_q;
  assign bus.bias_din   = bias_q;
  assign bus.shift_din  = shift_q;
endmodule
